alu_instr_encoder: RTL and testbench
====================================

// Module: alu_instr_encoder
// PURPOSE
// - Inverse of the ALU decode path: turns a request {kind, ALU ctl, regs, imm} into a legal RV32I word.
// - Requests arrive on a valid/ready port; encoded words are buffered in an output FIFO.
// - Illegal requests are reported on a separate error port.
// - Feeds the self-test instruction generator and the decoder/ALU closed-loop benches.
// PARAMETERS
// - FIFO_DEPTH  4  output FIFO entries; power of two, >= 2
// PORTS
// - clk             in   1    system clock, rising edge
// - rst_n           in   1    asynchronous active-low reset
// - in_valid        in   1    request valid
// - in_ready        out  1    request accepted when in_valid && in_ready
// - in_kind         in   3    0 OP, 1 OP_IMM, 2 BRANCH, 3 LOAD, 4 STORE; 5-7 illegal
// - in_ctl          in   `ALU_CTL_WIDTH  ALU control code (`ALU_* from alu_defs.sv)
// - in_mfunct3      in   3    funct3 for LOAD/STORE (width/sign); ignored otherwise
// - in_rd           in   5    destination register
// - in_rs1          in   5    source register 1
// - in_rs2          in   5    source register 2
// - in_imm          in   13   signed immediate / branch byte offset
// - out_valid       out  1    FIFO head valid
// - out_ready       in   1    consumer pops head when out_valid && out_ready
// - out_instr       out  32   encoded instruction at FIFO head
// - err_valid       out  1    one-cycle pulse: illegal request accepted and dropped
// - err_code        out  2    1 bad kind, 2 ctl illegal for kind, 3 imm range/alignment
// - enc_count       out  32   (ALU_ENC_STATS_EN only) legal encodings written to FIFO
// - err_count       out  16   (ALU_ENC_STATS_EN only) illegal requests, saturating
// BEHAVIOUR
// - Reset (async, on rst_n low): FIFO flushed, pointers/count 0; out_valid=0, out_instr=0;
//   err_valid=0, err_code=0; stats counters 0.
// - in_ready = (count < FIFO_DEPTH); it does not depend on out_ready.
// - Encode is combinational from the inputs. On acceptance a legal word is written to the FIFO.
// - Latency: request accepted at edge N appears at out_instr/out_valid after edge N (1 cycle) when the FIFO was empty.
// - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
// - FIFO preserves order. out_instr holds its value while out_valid && !out_ready.
// - Illegal request, when accepted: nothing is pushed; err_valid=1 with err_code on the next cycle.
//   Error check priority: kind, then ctl, then imm.
// - OP (0110011), R-type:
//   - funct7=0x20 for SUB/SRA, else 0x00.
//   - SEQ/SNE/SGE/SGEU are illegal (code 2).
// - OP_IMM (0010011), I-type, imm=in_imm[11:0]:
//   - SUB is illegal (code 2); SEQ/SNE/SGE/SGEU are illegal (code 2).
//   - in_imm must fit 12-bit signed (in_imm[12]==in_imm[11]), else code 3.
//   - SLL/SRL/SRA: shamt=in_imm[4:0]; in_imm[12:5] must be 0, else code 3.
//     imm[11:5]=0x20 for SRA, else 0x00.
// - BRANCH (1100011), B-type from in_imm[12:1]:
//   - funct3: SEQ 000, SNE 001, SLT 100, SGE 101, SLTU 110, SGEU 111; other ctl is code 2.
//   - in_imm[0]=1 is code 3.
// - LOAD (0000011) I-type, STORE (0100011) S-type:
//   - ctl must be ADD, else code 2.
//   - funct3=in_mfunct3; 12-bit range rule as OP_IMM (code 3).
// - funct3 for OP/OP_IMM: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
// - Reset asserted mid-stream drops all buffered words; no stale word is presented after release.
// CONFIGURATION
// - ALU_ENC_STATS_EN defined: enc_count (wrapping) and err_count (saturating at 0xFFFF) present.
//   Both are updated on the same edge as the FIFO push / error detection.
// - ALU_ENC_STATS_EN undefined: both ports and their counters are absent; all other behaviour is identical.
// TESTING
// - OP SUB, rd=3 rs1=1 rs2=2 -> out_instr=0x402081B3, out_valid 1 cycle after acceptance.
// - OP_IMM ADD, rd=1 rs1=0 imm=0x1FFF(-1) -> 0xFFF00093.
// - OP_IMM SRA, rd=4 rs1=4 imm=5 -> 0x40525213.
// - BRANCH SNE, rs1=1 rs2=2 imm=8 -> 0x00209463.
// - Illegal requests, each gives err_valid=1 with no FIFO push (err_count+1 if enabled):
//   - OP SGE -> err_code=2.
//   - BRANCH SEQ imm=3 -> err_code=3.
//   - kind=6 -> err_code=1.
// - out_ready=0, push 4 legal words -> in_ready=0 after 4th; then out_ready=1 -> 4 words drain in order.
//   During drain, push+pop in one cycle keeps count at 3.
// - 3 words buffered, pulse rst_n low mid-cycle -> out_valid=0 immediately; after release in_ready=1, count 0.

Source files
------------

// File: rtl/alu_instr_encoder.sv
// RV32I encoder: {kind, ALU ctl, regs, imm} request -> legal instruction word, buffered in an output FIFO.
// Define ALU_ENC_STATS_EN to add the enc_count / err_count statistics ports.

`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_SEQ  4'd10
`define ALU_SNE  4'd11
`define ALU_SGE  4'd12
`define ALU_SGEU 4'd13
`endif

module alu_instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_kind,
    input  logic [`ALU_CTL_WIDTH-1:0] in_ctl,
    input  logic [2:0]                in_mfunct3,
    input  logic [4:0]                in_rd,
    input  logic [4:0]                in_rs1,
    input  logic [4:0]                in_rs2,
    input  logic [12:0]               in_imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic                      err_valid,
    output logic [1:0]                err_code
`ifdef ALU_ENC_STATS_EN
    ,
    output logic [31:0]               enc_count,
    output logic [15:0]               err_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        KIND_OP     = 3'd0,
        KIND_OP_IMM = 3'd1,
        KIND_BRANCH = 3'd2,
        KIND_LOAD   = 3'd3,
        KIND_STORE  = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_KIND = 2'd1,
        ERR_CTL  = 2'd2,
        ERR_IMM  = 2'd3
    } err_e;

    // ------------------------------------------------------------------
    // Field lookup
    // ------------------------------------------------------------------
    logic [2:0]  alu_f3;
    logic        alu_f3_ok;
    logic [2:0]  br_f3;
    logic        br_f3_ok;
    logic        is_shift;
    logic        is_alt;
    logic        imm_fits12;
    logic        shamt_ok;
    logic [11:0] opi_imm;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_f3    = 3'b000;
        alu_f3_ok = 1'b1;
        case (in_ctl)
            `ALU_ADD, `ALU_SUB: alu_f3 = 3'b000;
            `ALU_SLL:           alu_f3 = 3'b001;
            `ALU_SLT:           alu_f3 = 3'b010;
            `ALU_SLTU:          alu_f3 = 3'b011;
            `ALU_XOR:           alu_f3 = 3'b100;
            `ALU_SRL, `ALU_SRA: alu_f3 = 3'b101;
            `ALU_OR:            alu_f3 = 3'b110;
            `ALU_AND:           alu_f3 = 3'b111;
            default:            alu_f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        br_f3    = 3'b000;
        br_f3_ok = 1'b1;
        case (in_ctl)
            `ALU_SEQ:  br_f3 = 3'b000;
            `ALU_SNE:  br_f3 = 3'b001;
            `ALU_SLT:  br_f3 = 3'b100;
            `ALU_SGE:  br_f3 = 3'b101;
            `ALU_SLTU: br_f3 = 3'b110;
            `ALU_SGEU: br_f3 = 3'b111;
            default:   br_f3_ok = 1'b0;
        endcase
    end

    assign is_shift   = (in_ctl == `ALU_SLL) || (in_ctl == `ALU_SRL) || (in_ctl == `ALU_SRA);
    assign is_alt     = (in_ctl == `ALU_SUB) || (in_ctl == `ALU_SRA);
    assign imm_fits12 = (in_imm[12] == in_imm[11]);
    assign shamt_ok   = (in_imm[12:5] == 8'h00);
    assign opi_imm    = is_shift ? {((in_ctl == `ALU_SRA) ? 7'h20 : 7'h00), in_imm[4:0]}
                                 : in_imm[11:0];

    // ------------------------------------------------------------------
    // Encode and legality check (priority: kind, ctl, imm)
    // ------------------------------------------------------------------
    err_e        err_c;
    logic [31:0] instr_c;

    always_comb begin
        err_c   = ERR_NONE;
        instr_c = 32'h0;
        case (in_kind)
            KIND_OP: begin
                if (!alu_f3_ok) begin
                    err_c = ERR_CTL;
                end else begin
                    instr_c = {(is_alt ? 7'h20 : 7'h00), in_rs2, in_rs1, alu_f3, in_rd, OPC_OP};
                end
            end
            KIND_OP_IMM: begin
                if (!alu_f3_ok || (in_ctl == `ALU_SUB)) begin
                    err_c = ERR_CTL;
                end else if (is_shift ? !shamt_ok : !imm_fits12) begin
                    err_c = ERR_IMM;
                end else begin
                    instr_c = {opi_imm, in_rs1, alu_f3, in_rd, OPC_OP_IMM};
                end
            end
            KIND_BRANCH: begin
                if (!br_f3_ok) begin
                    err_c = ERR_CTL;
                end else if (in_imm[0]) begin
                    err_c = ERR_IMM;
                end else begin
                    instr_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_f3,
                               in_imm[4:1], in_imm[11], OPC_BRANCH};
                end
            end
            KIND_LOAD: begin
                if (in_ctl != `ALU_ADD) begin
                    err_c = ERR_CTL;
                end else if (!imm_fits12) begin
                    err_c = ERR_IMM;
                end else begin
                    instr_c = {in_imm[11:0], in_rs1, in_mfunct3, in_rd, OPC_LOAD};
                end
            end
            KIND_STORE: begin
                if (in_ctl != `ALU_ADD) begin
                    err_c = ERR_CTL;
                end else if (!imm_fits12) begin
                    err_c = ERR_IMM;
                end else begin
                    instr_c = {in_imm[11:5], in_rs2, in_rs1, in_mfunct3, in_imm[4:0], OPC_STORE};
                end
            end
            default: err_c = ERR_KIND;
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_valid_q;
    err_e             err_code_q;
    logic             accept;
    logic             push;
    logic             pop;
    logic             accept_err;

    assign in_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    assign out_valid  = (count_q != '0);
    assign accept     = in_valid && in_ready;
    assign push       = accept && (err_c == ERR_NONE);
    assign accept_err = accept && (err_c != ERR_NONE);
    assign pop        = out_valid && out_ready;

    // Gating with out_valid keeps stale storage invisible after reset.
    assign out_instr  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;

    // Depth is a power of two, so plain increment wraps the pointers.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage array has no reset; validity comes from count_q, so it maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr_c;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_valid_q <= accept_err;
            err_code_q  <= accept_err ? err_c : ERR_NONE;
        end
    end

`ifdef ALU_ENC_STATS_EN
    logic [31:0] enc_count_q;
    logic [15:0] err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_q <= 32'h0;
            err_count_q <= 16'h0;
        end else begin
            if (push) begin
                enc_count_q <= enc_count_q + 32'h1;
            end
            if (accept_err && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'h1;
            end
        end
    end

    assign enc_count = enc_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Scoreboard bench for alu_instr_encoder: directed spec vectors plus randomized requests
// checked against an arithmetic reference model of the RV32I encodings.

`timescale 1ns/1ps

`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_SEQ  4'd10
`define ALU_SNE  4'd11
`define ALU_SGE  4'd12
`define ALU_SGEU 4'd13
`endif

module tb_alu_instr_encoder;

  localparam int DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [2:0]                in_kind = '0;
  logic [`ALU_CTL_WIDTH-1:0] in_ctl = '0;
  logic [2:0]                in_mfunct3 = '0;
  logic [4:0]                in_rd = '0;
  logic [4:0]                in_rs1 = '0;
  logic [4:0]                in_rs2 = '0;
  logic [12:0]               in_imm = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [31:0]               out_instr;
  logic                      err_valid;
  logic [1:0]                err_code;
`ifdef ALU_ENC_STATS_EN
  logic [31:0]               enc_count;
  logic [15:0]               err_count;
`endif

  alu_instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_ctl     (in_ctl),
    .in_mfunct3 (in_mfunct3),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .err_valid  (err_valid),
    .err_code   (err_code)
`ifdef ALU_ENC_STATS_EN
    ,
    .enc_count  (enc_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  err_q[$];
  int unsigned exp_enc = 0;
  int unsigned exp_err = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  function automatic int alu_f3(input logic [3:0] c);
    case (c)
      `ALU_ADD, `ALU_SUB: return 0;
      `ALU_SLL:           return 1;
      `ALU_SLT:           return 2;
      `ALU_SLTU:          return 3;
      `ALU_XOR:           return 4;
      `ALU_SRL, `ALU_SRA: return 5;
      `ALU_OR:            return 6;
      `ALU_AND:           return 7;
      default:            return -1;
    endcase
  endfunction

  function automatic int br_f3(input logic [3:0] c);
    case (c)
      `ALU_SEQ:  return 0;
      `ALU_SNE:  return 1;
      `ALU_SLT:  return 4;
      `ALU_SGE:  return 5;
      `ALU_SLTU: return 6;
      `ALU_SGEU: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic void model(input logic [2:0] k, input logic [3:0] c, input logic [2:0] mf,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [12:0] im, output logic [1:0] code, output logic [31:0] w);
    int          v;
    int          f3;
    logic [31:0] u;
    logic [31:0] base;
    bit          shift;
    v     = int'($signed(im));
    u     = 32'(v);
    code  = 2'd0;
    w     = 32'h0;
    shift = (c == `ALU_SLL) || (c == `ALU_SRL) || (c == `ALU_SRA);
    if (k > 3'd4) begin
      code = 2'd1;
      return;
    end
    base = (32'(s1) << 15);
    case (k)
      3'd0: begin
        f3 = alu_f3(c);
        if (f3 < 0) code = 2'd2;
        else w = (((c == `ALU_SUB) || (c == `ALU_SRA)) ? 32'h4000_0000 : 32'h0) | (32'(s2) << 20)
                 | base | (32'(f3) << 12) | (32'(d) << 7) | 32'h33;
      end
      3'd1: begin
        f3 = alu_f3(c);
        if (f3 < 0 || c == `ALU_SUB) code = 2'd2;
        else if (shift && (v < 0 || v > 31)) code = 2'd3;
        else if (!shift && (v < -2048 || v > 2047)) code = 2'd3;
        else w = ((shift ? ((c == `ALU_SRA) ? 32'h400 : 32'h0) + 32'(v) : (u & 32'hFFF)) << 20)
                 | base | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
      end
      3'd2: begin
        f3 = br_f3(c);
        if (f3 < 0) code = 2'd2;
        else if (v % 2 != 0) code = 2'd3;
        else w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (32'(s2) << 20) | base
                 | (32'(f3) << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      3'd3: begin
        if (c != `ALU_ADD) code = 2'd2;
        else if (v < -2048 || v > 2047) code = 2'd3;
        else w = ((u & 32'hFFF) << 20) | base | (32'(mf) << 12) | (32'(d) << 7) | 32'h03;
      end
      default: begin
        if (c != `ALU_ADD) code = 2'd2;
        else if (v < -2048 || v > 2047) code = 2'd3;
        else w = (((u >> 5) & 127) << 25) | (32'(s2) << 20) | base | (32'(mf) << 12)
                 | ((u & 31) << 7) | 32'h23;
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Entered and left at posedge+1; pushes the expected response on the accepting edge.
  task automatic send(input logic [2:0] k, input logic [3:0] c, input logic [2:0] mf,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [12:0] im);
    bit          acc = 1'b0;
    logic [1:0]  code;
    logic [31:0] w;
    model(k, c, mf, d, s1, s2, im, code, w);
    in_valid = 1'b1; in_kind = k; in_ctl = c; in_mfunct3 = mf;
    in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rand_ready && !acc) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    if (!acc) begin
      flag_fail("accept_timeout");
    end else if (code == 2'd0) begin
      exp_q.push_back(w);
      exp_enc++;
    end else begin
      err_q.push_back(code);
      if (exp_err != 32'hFFFF) exp_err++;
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    if (!done) flag_fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) flag_fail("spurious_word");
        else check("fifo_word", out_instr, exp_q.pop_front());
      end
      if (err_valid) begin
        if (err_q.size() == 0) flag_fail("spurious_err");
        else check("err_code", 32'(err_code), 32'(err_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [12:0] imm_edges [8];

  initial begin
    imm_edges = '{13'h07FF, 13'h0800, 13'h1800, 13'h17FF, 13'h0020, 13'h001F, 13'h0FFF, 13'h1000};

    #1 rst_n = 1'b0;
    #11;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_err_valid", 32'(err_valid), 32'h0);
    check("rst_err_code",  32'(err_code), 32'h0);
    check("rst_in_ready",  32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Spec encodings, each into an empty FIFO with the consumer stalled
    out_ready = 1'b0;
    send(3'd0, `ALU_SUB, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    @(negedge clk);
    check("op_sub_valid", 32'(out_valid), 32'h1);
    check("op_sub_word", out_instr, 32'h402081B3);
    @(posedge clk); #1; drain(); out_ready = 1'b0;

    send(3'd1, `ALU_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 13'h1FFF);
    @(negedge clk);
    check("addi_m1_word", out_instr, 32'hFFF00093);
    @(posedge clk); #1; drain(); out_ready = 1'b0;

    send(3'd1, `ALU_SRA, 3'd0, 5'd4, 5'd4, 5'd0, 13'd5);
    @(negedge clk);
    check("srai_word", out_instr, 32'h40525213);
    @(posedge clk); #1; drain(); out_ready = 1'b0;

    send(3'd2, `ALU_SNE, 3'd0, 5'd0, 5'd1, 5'd2, 13'd8);
    @(negedge clk);
    check("bne_word", out_instr, 32'h00209463);
    @(posedge clk); #1; drain();

    // Illegal requests: error pulse, nothing pushed
    send(3'd0, `ALU_SGE, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    @(negedge clk);
    check("op_sge_err_valid", 32'(err_valid), 32'h1);
    check("op_sge_err_code", 32'(err_code), 32'h2);
    check("op_sge_no_push", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    send(3'd2, `ALU_SEQ, 3'd0, 5'd0, 5'd1, 5'd2, 13'd3);
    @(negedge clk);
    check("beq_odd_err_code", 32'(err_code), 32'h3);
    @(posedge clk); #1;
    send(3'd6, `ALU_ADD, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    @(negedge clk);
    check("kind6_err_code", 32'(err_code), 32'h1);
    @(posedge clk); #1;
    check("err_pulse_one_cycle", 32'(err_valid), 32'h0);

    // Range and ctl boundaries, checked through the scoreboard
    send(3'd1, `ALU_ADD, 3'd0, 5'd5, 5'd6, 5'd0, 13'h07FF);
    send(3'd1, `ALU_ADD, 3'd0, 5'd5, 5'd6, 5'd0, 13'h0800);
    send(3'd1, `ALU_ADD, 3'd0, 5'd5, 5'd6, 5'd0, 13'h1800);
    send(3'd1, `ALU_SLL, 3'd0, 5'd5, 5'd6, 5'd0, 13'd32);
    send(3'd1, `ALU_SLL, 3'd0, 5'd5, 5'd6, 5'd0, 13'd31);
    send(3'd1, `ALU_SUB, 3'd0, 5'd5, 5'd6, 5'd0, 13'd1);
    send(3'd3, `ALU_SUB, 3'd2, 5'd5, 5'd6, 5'd0, 13'd4);
    send(3'd4, `ALU_ADD, 3'd2, 5'd0, 5'd6, 5'd7, 13'h1FE0);
    send(3'd2, `ALU_SGEU, 3'd0, 5'd0, 5'd6, 5'd7, 13'h1000);
    drain();

    // Reset mid-stream drops buffered words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd0, `ALU_ADD, 3'd0, 5'(i + 1), 5'd2, 5'd3, 13'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_instr", out_instr, 32'h0);
    exp_q.delete(); err_q.delete(); exp_enc = 0; exp_err = 0;
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    check("post_rst_out_valid", 32'(out_valid), 32'h0);
`ifdef ALU_ENC_STATS_EN
    check("post_rst_enc_count", enc_count, 32'h0);
    check("post_rst_err_count", 32'(err_count), 32'h0);
`endif
    @(posedge clk); #1;

    // Fill to depth, then push+pop in one cycle
    for (int i = 0; i < DEPTH; i++)
      send(3'd0, 4'($urandom_range(0, 9)), 3'd0, 5'($urandom), 5'($urandom), 5'($urandom), 13'd0);
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_out_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_pop_in_ready", 32'(in_ready), 32'h1);
    send(3'd0, `ALU_AND, 3'd0, 5'd9, 5'd10, 5'd11, 13'd0);
    check("push_pop_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b0;
    send(3'd0, `ALU_XOR, 3'd0, 5'd12, 5'd13, 5'd14, 13'd0);
    check("push_pop_kept_count3", 32'(in_ready), 32'h0);
    drain();

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  k;
      logic [12:0] im;
      k = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      case ($urandom_range(0, 3))
        0:       im = 13'($urandom_range(0, 31));
        1:       im = 13'($urandom);
        2:       im = imm_edges[$urandom_range(0, 7)];
        default: im = 13'($urandom_range(0, 4094)) - 13'd2047;
      endcase
      send(k, 4'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    drain();

    check("words_outstanding", 32'(exp_q.size()), 32'h0);
    check("errs_outstanding", 32'(err_q.size()), 32'h0);
`ifdef ALU_ENC_STATS_EN
    check("enc_count", enc_count, exp_enc);
    check("err_count", 32'(err_count), exp_err);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
